// File: rtl/tc_pkg.sv
// rtl/tc_pkg.sv - shared types and helpers for the serial twos-complement unit
package tc_pkg;

  typedef enum logic [1:0] {
    TC_PASS = 2'b00,
    TC_ONES = 2'b01,
    TC_NEG  = 2'b10,
    TC_ABS  = 2'b11
  } tc_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } tc_state_e;

  function automatic int tc_clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/tc_bit_cell.sv
// rtl/tc_bit_cell.sv - one-bit conversion rule: copy through the first 1, then invert
module tc_bit_cell
  import tc_pkg::*;
(
  input  logic     b,
  input  logic     seen_one,
  input  tc_mode_e mode,
  output logic     r,
  output logic     seen_one_next
);

  always_comb begin
    r             = b;
    seen_one_next = seen_one;
    case (mode)
      TC_ONES: r = ~b;
      TC_NEG: begin
        r             = seen_one ? ~b : b;
        seen_one_next = seen_one | b;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/serial_twos_comp_unit.sv
// rtl/serial_twos_comp_unit.sv - bit-serial pass/ones/negate/abs converter with valid/ready handshakes
module serial_twos_comp_unit
  import tc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf
);

  localparam int CW = tc_clog2(WIDTH + 1);

  if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
    $error("serial_twos_comp_unit: WIDTH must be in 2..64");
  end

  tc_state_e        state_q, state_d;
  tc_mode_e         mode_q;
  tc_mode_e         eff_mode;
  logic [WIDTH-1:0] sreg_q;
  logic [WIDTH-1:0] res_q;
  logic [CW-1:0]    cnt_q;
  logic             seen_one_q;
  logic             ovf_q;
  logic             bit_r;
  logic             seen_one_next;
  logic             last_bit;

  // Abs collapses to negate or pass once, so the shifter only knows three rules.
  always_comb begin
    eff_mode = tc_mode_e'(in_mode);
    if (tc_mode_e'(in_mode) == TC_ABS)
      eff_mode = in_data[WIDTH-1] ? TC_NEG : TC_PASS;
  end

  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  tc_bit_cell u_cell (
    .b             (sreg_q[0]),
    .seen_one      (seen_one_q),
    .mode          (mode_q),
    .r             (bit_r),
    .seen_one_next (seen_one_next)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (last_bit) state_d = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sreg_q     <= '0;
      res_q      <= '0;
      cnt_q      <= '0;
      seen_one_q <= 1'b0;
      ovf_q      <= 1'b0;
      mode_q     <= TC_PASS;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            sreg_q     <= in_data;
            res_q      <= '0;
            mode_q     <= eff_mode;
            cnt_q      <= '0;
            seen_one_q <= 1'b0;
            ovf_q      <= 1'b0;
          end
        end
        ST_SHIFT: begin
          sreg_q     <= sreg_q >> 1;
          res_q      <= {bit_r, res_q[WIDTH-1:1]};
          cnt_q      <= cnt_q + 1'b1;
          seen_one_q <= seen_one_next;
          // A 1 reaching the MSB with no earlier 1 means the operand was 100..0.
          if (last_bit)
            ovf_q <= (mode_q == TC_NEG) && sreg_q[0] && !seen_one_q;
        end
        default: ;
      endcase
    end
  end

  assign out_data = res_q;
  assign out_ovf  = ovf_q;

endmodule

// File: tb/tb_serial_twos_comp_unit.sv
// tb/tb_serial_twos_comp_unit.sv - directed table-driven bench for serial_twos_comp_unit
module tb_serial_twos_comp_unit;

  logic       clk = 1'b0;
  logic       reset;

  logic       v3_in_valid, v3_in_ready, v3_out_valid, v3_out_ready, v3_out_ovf;
  logic [2:0] v3_in_data, v3_out_data;
  logic [1:0] v3_in_mode;

  logic       v8_in_valid, v8_in_ready, v8_out_valid, v8_out_ready, v8_out_ovf;
  logic [7:0] v8_in_data, v8_out_data;
  logic [1:0] v8_in_mode;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  serial_twos_comp_unit #(.WIDTH(3)) u_dut3 (
    .clk(clk), .reset(reset),
    .in_valid(v3_in_valid), .in_ready(v3_in_ready), .in_data(v3_in_data), .in_mode(v3_in_mode),
    .out_valid(v3_out_valid), .out_ready(v3_out_ready), .out_data(v3_out_data), .out_ovf(v3_out_ovf)
  );

  serial_twos_comp_unit #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset(reset),
    .in_valid(v8_in_valid), .in_ready(v8_in_ready), .in_data(v8_in_data), .in_mode(v8_in_mode),
    .out_valid(v8_out_valid), .out_ready(v8_out_ready), .out_data(v8_out_data), .out_ovf(v8_out_ovf)
  );

  typedef struct {
    string      name;
    logic [1:0] mode;
    logic [7:0] data;
    logic [7:0] exp_data;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Latency counts rising edges from and including the accepting edge up to the one that raises out_valid.
  task automatic run8(input logic [1:0] mode, input logic [7:0] data,
                      output logic [7:0] got, output logic gov, output int lat, output logic idle_after);
    @(negedge clk);
    v8_in_valid = 1'b1; v8_in_data = data; v8_in_mode = mode;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    v8_in_valid = 1'b0; v8_in_data = ~data; v8_in_mode = ~mode;
    while (!v8_out_valid && lat < 200) begin
      @(posedge clk); lat++;
      @(negedge clk);
    end
    got = v8_out_data; gov = v8_out_ovf;
    v8_out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v8_out_ready = 1'b0;
    idle_after = v8_in_ready && !v8_out_valid;
  endtask

  task automatic run3(input logic [1:0] mode, input logic [2:0] data,
                      output logic [2:0] got, output logic gov, output int lat);
    @(negedge clk);
    v3_in_valid = 1'b1; v3_in_data = data; v3_in_mode = mode;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    v3_in_valid = 1'b0;
    while (!v3_out_valid && lat < 200) begin
      @(posedge clk); lat++;
      @(negedge clk);
    end
    got = v3_out_data; gov = v3_out_ovf;
    v3_out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v3_out_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] g8;
    logic [2:0] g3;
    logic       gov, idle_after, stable;
    int         lat;

    vecs[0]  = '{"neg_05",  2'b10, 8'h05, 8'hFB, 1'b0};
    vecs[1]  = '{"abs_FB",  2'b11, 8'hFB, 8'h05, 1'b0};
    vecs[2]  = '{"abs_05",  2'b11, 8'h05, 8'h05, 1'b0};
    vecs[3]  = '{"neg_80",  2'b10, 8'h80, 8'h80, 1'b1};
    vecs[4]  = '{"neg_00",  2'b10, 8'h00, 8'h00, 1'b0};
    vecs[5]  = '{"ones_5A", 2'b01, 8'h5A, 8'hA5, 1'b0};
    vecs[6]  = '{"pass_3C", 2'b00, 8'h3C, 8'h3C, 1'b0};
    vecs[7]  = '{"abs_80",  2'b11, 8'h80, 8'h80, 1'b1};
    vecs[8]  = '{"ones_80", 2'b01, 8'h80, 8'h7F, 1'b0};
    vecs[9]  = '{"pass_80", 2'b00, 8'h80, 8'h80, 1'b0};
    vecs[10] = '{"neg_FF",  2'b10, 8'hFF, 8'h01, 1'b0};

    reset = 1'b1;
    v3_in_valid = 1'b0; v3_in_data = '0; v3_in_mode = '0; v3_out_ready = 1'b0;
    v8_in_valid = 1'b0; v8_in_data = '0; v8_in_mode = '0; v8_out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready",  v8_in_ready,  1'b1);
    chk("rst_out_valid", v8_out_valid, 1'b0);
    chk("rst_out_data",  v8_out_data,  8'h00);
    chk("rst_out_ovf",   v8_out_ovf,   1'b0);
    chk("rst3_in_ready", v3_in_ready,  1'b1);
    reset = 1'b0;

    // out_ready in IDLE must not produce anything.
    v8_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    v8_out_ready = 1'b0;
    chk("idle_ready_no_valid", {v8_in_ready, v8_out_valid}, 2'b10);

    run3(2'b10, 3'b101, g3, gov, lat);
    chk("w3_neg_101_data", g3, 3'b011);
    chk("w3_neg_101_ovf",  gov, 1'b0);
    chk("w3_neg_101_lat",  lat, 4);
    run3(2'b10, 3'b100, g3, gov, lat);
    chk("w3_neg_100_data", g3, 3'b100);
    chk("w3_neg_100_ovf",  gov, 1'b1);

    for (int i = 0; i < 11; i++) begin
      run8(vecs[i].mode, vecs[i].data, g8, gov, lat, idle_after);
      chk({vecs[i].name, "_data"}, g8, vecs[i].exp_data);
      chk({vecs[i].name, "_ovf"},  gov, vecs[i].exp_ovf);
      chk({vecs[i].name, "_lat"},  lat, 9);
      chk({vecs[i].name, "_idle"}, idle_after, 1'b1);
    end

    // Backpressure: DONE holds with stable outputs while a stray word is offered.
    @(negedge clk);
    v8_in_valid = 1'b1; v8_in_data = 8'h05; v8_in_mode = 2'b10;
    @(posedge clk);
    @(negedge clk);
    v8_in_valid = 1'b0;
    lat = 0;
    while (!v8_out_valid && lat < 200) begin
      @(posedge clk); lat++;
      @(negedge clk);
    end
    chk("hold_reached_done", v8_out_valid, 1'b1);
    stable = 1'b1;
    for (int c = 0; c < 20; c++) begin
      v8_in_valid = (c >= 5 && c < 15);
      v8_in_data  = 8'h33; v8_in_mode = 2'b01;
      if (!v8_out_valid || v8_out_data !== 8'hFB || v8_in_ready || v8_out_ovf) stable = 1'b0;
      @(posedge clk);
      @(negedge clk);
    end
    v8_in_valid = 1'b0;
    chk("hold_stable", stable, 1'b1);
    chk("hold_data", v8_out_data, 8'hFB);
    v8_out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v8_out_ready = 1'b0;
    chk("hold_release_idle", {v8_in_ready, v8_out_valid}, 2'b10);
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("stray_not_accepted", {v8_in_ready, v8_out_valid}, 2'b10);

    // Reset while the 4th bit is being shifted.
    v8_in_valid = 1'b1; v8_in_data = 8'h55; v8_in_mode = 2'b10;
    @(posedge clk);
    @(negedge clk);
    v8_in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("mid_shift_busy", v8_in_ready, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("abort_in_ready",  v8_in_ready,  1'b1);
    chk("abort_out_valid", v8_out_valid, 1'b0);
    chk("abort_out_data",  v8_out_data,  8'h00);
    chk("abort_out_ovf",   v8_out_ovf,   1'b0);
    run8(2'b10, 8'h01, g8, gov, lat, idle_after);
    chk("post_rst_neg01_data", g8, 8'hFF);
    chk("post_rst_neg01_ovf",  gov, 1'b0);
    chk("post_rst_neg01_lat",  lat, 9);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
